// File: rtl/rvh_l1d_pkg.sv
// Shared widths, STU opcode map and AMO FSM states for the L1D bank AMO unit.
package rvh_l1d_pkg;
  localparam int ROB_TAG_WIDTH  = 4;
  localparam int PREG_TAG_WIDTH = 6;
  localparam int STU_OP_WIDTH   = 5;
  localparam int PADDR_WIDTH    = 56;
  localparam int XLEN           = 64;
  localparam int WLEN           = 32;

  typedef enum logic [STU_OP_WIDTH-1:0] {
    STU_LRW = 5'd7, STU_LRD, STU_SCW, STU_SCD,
    STU_AMOSWAPW, STU_AMOSWAPD, STU_AMOADDW, STU_AMOADDD,
    STU_AMOANDW, STU_AMOANDD, STU_AMOORW, STU_AMOORD,
    STU_AMOXORW, STU_AMOXORD, STU_AMOMAXW, STU_AMOMAXD,
    STU_AMOMAXUW, STU_AMOMAXUD, STU_AMOMINW, STU_AMOMIND,
    STU_AMOMINUW, STU_AMOMINUD
  } amo_op_e;

  typedef enum logic [2:0] {
    AMO_IDLE, AMO_RD_REQ, AMO_RD_WAIT, AMO_WR_REQ, AMO_RESP
  } amo_state_e;

  // Word variants sit on odd opcodes throughout the map.
  function automatic logic is_amo_word(input amo_op_e op);
    return op[0];
  endfunction
endpackage

// File: rtl/rvh_l1d_amo_alu.sv
// Combinational AMO compute; for word ops only the low 32 bits of new_val are meaningful.
module rvh_l1d_amo_alu
  import rvh_l1d_pkg::*;
(
  input  amo_op_e         opcode,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_word,
  output logic [XLEN-1:0] new_val
);
  logic [XLEN-1:0] a_s, b_s, a_u, b_u;
  logic            lt_s, lt_u;

  // Extending word operands to 64 bits lets one comparator serve both widths.
  assign a_s  = is_word ? {{WLEN{old[WLEN-1]}}, old[WLEN-1:0]} : old;
  assign b_s  = is_word ? {{WLEN{rs2[WLEN-1]}}, rs2[WLEN-1:0]} : rs2;
  assign a_u  = is_word ? {{WLEN{1'b0}}, old[WLEN-1:0]} : old;
  assign b_u  = is_word ? {{WLEN{1'b0}}, rs2[WLEN-1:0]} : rs2;
  assign lt_s = $signed(a_s) < $signed(b_s);
  assign lt_u = a_u < b_u;

  always_comb begin
    new_val = old;
    case (opcode)
      STU_SCW, STU_SCD, STU_AMOSWAPW, STU_AMOSWAPD: new_val = rs2;
      STU_AMOADDW, STU_AMOADDD:   new_val = old + rs2;
      STU_AMOANDW, STU_AMOANDD:   new_val = old & rs2;
      STU_AMOORW,  STU_AMOORD:    new_val = old | rs2;
      STU_AMOXORW, STU_AMOXORD:   new_val = old ^ rs2;
      STU_AMOMAXW, STU_AMOMAXD:   new_val = lt_s ? rs2 : old;
      STU_AMOMINW, STU_AMOMIND:   new_val = lt_s ? old : rs2;
      STU_AMOMAXUW, STU_AMOMAXUD: new_val = lt_u ? rs2 : old;
      STU_AMOMINUW, STU_AMOMINUD: new_val = lt_u ? old : rs2;
      default:                    new_val = old;
    endcase
  end
endmodule

// File: rtl/rvh_l1d_bank_amo_unit.sv
// L1D bank AMO/LR/SC sequencer: read, modify, write, single-cycle ROB writeback.
// Optional misaligned-address exception check: RVH_L1D_AMO_MISALIGN_CHK_EN.
module rvh_l1d_bank_amo_unit
  import rvh_l1d_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      amo_req_vld_i,
  output logic                      amo_req_rdy_o,
  input  logic [ROB_TAG_WIDTH-1:0]  amo_req_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0] amo_req_prd_i,
  input  logic [STU_OP_WIDTH-1:0]   amo_req_opcode_i,
  input  logic [PADDR_WIDTH-1:0]    amo_req_paddr_i,
  input  logic [XLEN-1:0]           amo_req_data_i,
  input  logic                      amo_req_sc_rt_check_succ_i,
  output logic                      rd_req_vld_o,
  input  logic                      rd_req_rdy_i,
  output logic [PADDR_WIDTH-1:0]    rd_req_paddr_o,
  input  logic                      rd_resp_vld_i,
  input  logic [XLEN-1:0]           rd_resp_data_i,
  output logic                      wr_req_vld_o,
  input  logic                      wr_req_rdy_i,
  output logic [PADDR_WIDTH-1:0]    wr_req_paddr_o,
  output logic [XLEN-1:0]           wr_req_data_o,
  output logic [7:0]                wr_req_mask_o,
  output logic                      l1d_rob_wb_vld_o,
  output logic [ROB_TAG_WIDTH-1:0]  l1d_rob_wb_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0] l1d_rob_wb_prd_o,
  output logic [XLEN-1:0]           l1d_rob_wb_data_o,
  output logic                      l1d_rob_wb_excp_o
);
  amo_state_e                state_q, state_d;
  amo_op_e                   req_op, op_q;
  logic [ROB_TAG_WIDTH-1:0]  rob_tag_q;
  logic [PREG_TAG_WIDTH-1:0] prd_q;
  logic [PADDR_WIDTH-1:2]    paddr_q;
  logic [XLEN-1:0]           new_q, wb_data_q, old_ext, alu_new;
  logic [WLEN-1:0]           old_half;
  logic                      req_hsk, req_is_sc, req_misalign, is_word_q, is_lr_q, resp_take;

  assign req_op        = amo_op_e'(amo_req_opcode_i);
  assign amo_req_rdy_o = (state_q == AMO_IDLE);
  assign req_hsk       = amo_req_vld_i & amo_req_rdy_o;
  assign req_is_sc     = (req_op == STU_SCW) || (req_op == STU_SCD);
  assign is_word_q     = is_amo_word(op_q);
  assign is_lr_q       = (op_q == STU_LRW) || (op_q == STU_LRD);
  assign resp_take     = (state_q == AMO_RD_WAIT) & rd_resp_vld_i;

`ifdef RVH_L1D_AMO_MISALIGN_CHK_EN
  logic excp_q;
  assign req_misalign      = is_amo_word(req_op) ? (|amo_req_paddr_i[1:0])
                                                 : (|amo_req_paddr_i[2:0]);
  assign l1d_rob_wb_excp_o = (state_q == AMO_RESP) & excp_q;
  always_ff @(posedge clk) if (req_hsk) excp_q <= req_misalign;
`else
  logic unused_paddr_lo;
  assign unused_paddr_lo   = ^amo_req_paddr_i[1:0];
  assign req_misalign      = 1'b0;
  assign l1d_rob_wb_excp_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      AMO_IDLE:
        if (req_hsk) begin
          if (req_misalign)   state_d = AMO_RESP;
          else if (req_is_sc) state_d = amo_req_sc_rt_check_succ_i ? AMO_WR_REQ : AMO_RESP;
          else                state_d = AMO_RD_REQ;
        end
      AMO_RD_REQ:  if (rd_req_rdy_i) state_d = AMO_RD_WAIT;
      AMO_RD_WAIT: if (rd_resp_vld_i) state_d = is_lr_q ? AMO_RESP : AMO_WR_REQ;
      AMO_WR_REQ:  if (wr_req_rdy_i) state_d = AMO_RESP;
      AMO_RESP:    state_d = AMO_IDLE;
      default:     state_d = AMO_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= AMO_IDLE;
    else     state_q <= state_d;
  end

  // Word ops see the addressed half sign-extended, which is also the writeback value.
  assign old_half = paddr_q[2] ? rd_resp_data_i[XLEN-1:WLEN] : rd_resp_data_i[WLEN-1:0];
  assign old_ext  = is_word_q ? {{WLEN{old_half[WLEN-1]}}, old_half} : rd_resp_data_i;

  rvh_l1d_amo_alu u_alu (
    .opcode (op_q),
    .old    (old_ext),
    .rs2    (new_q),
    .is_word(is_word_q),
    .new_val(alu_new)
  );

  // new_q holds rs2 until the read returns, then the computed write value.
  always_ff @(posedge clk) begin
    if (req_hsk) begin
      op_q      <= req_op;
      rob_tag_q <= amo_req_rob_tag_i;
      prd_q     <= amo_req_prd_i;
      paddr_q   <= amo_req_paddr_i[PADDR_WIDTH-1:2];
      new_q     <= amo_req_data_i;
      wb_data_q <= (req_is_sc && !req_misalign && !amo_req_sc_rt_check_succ_i) ? 64'd1 : 64'd0;
    end else if (resp_take) begin
      new_q     <= alu_new;
      wb_data_q <= old_ext;
    end
  end

  assign rd_req_vld_o         = (state_q == AMO_RD_REQ);
  assign rd_req_paddr_o       = {paddr_q[PADDR_WIDTH-1:3], 3'b000};
  assign wr_req_vld_o         = (state_q == AMO_WR_REQ);
  assign wr_req_paddr_o       = {paddr_q[PADDR_WIDTH-1:3], 3'b000};
  assign wr_req_data_o        = is_word_q ? {2{new_q[WLEN-1:0]}} : new_q;
  assign wr_req_mask_o        = !is_word_q ? 8'hFF : (paddr_q[2] ? 8'hF0 : 8'h0F);
  assign l1d_rob_wb_vld_o     = (state_q == AMO_RESP);
  assign l1d_rob_wb_rob_tag_o = rob_tag_q;
  assign l1d_rob_wb_prd_o     = prd_q;
  assign l1d_rob_wb_data_o    = wb_data_q;
endmodule
